// File: rtl/freq_div_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_div_multi_pkg
//  Description : Shared panel timing constants and per-channel output bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package freq_div_multi_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int REFRESH_HZ  = 240;
    localparam int DIV_1HZ     = CLK_HZ;
    localparam int DIV_1KHZ    = CLK_HZ / 1_000;
    localparam int DIV_REFRESH = CLK_HZ / REFRESH_HZ;
    localparam int DIV_MIN     = 2;

    typedef struct packed {
        logic tick;
        logic sq;
        logic pend;
    } ch_out_t;

endpackage : freq_div_multi_pkg
`default_nettype wire

// File: rtl/freq_div_channel.sv
`default_nettype none
// ============================================================================
//  Module      : freq_div_channel
//  Description : One divider channel: counter, active/shadow divisor,
//                registered tick, square wave and pending-update flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_div_channel
    import freq_div_multi_pkg::*;
#(
    parameter int DIV_W   = 26,
    parameter int DEF_DIV = DIV_1HZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_resync,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wdata,
    output ch_out_t          o_out
);

    localparam logic [DIV_W-1:0] c_def = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] c_one = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt_q, w_cnt_d;
    logic [DIV_W-1:0] r_act_q, w_act_d;
    logic [DIV_W-1:0] r_shd_q, w_shd_d;
    logic             r_tick_q, w_tick_d;
    logic             r_sq_q, w_sq_d;
    logic             r_pend_q, w_pend_d;

    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_half;
    logic             w_wrap;

    assign w_cnt_inc = r_cnt_q + c_one;
    assign w_half    = r_act_q >> 1;
    // >= rather than == keeps the counter bounded if a disabled-channel load
    // shrinks the divisor below the frozen count.
    assign w_wrap    = (r_cnt_q >= (r_act_q - c_one));

    always_comb begin
        w_cnt_d  = r_cnt_q;
        w_act_d  = r_act_q;
        w_shd_d  = r_shd_q;
        w_tick_d = 1'b0;
        w_sq_d   = r_sq_q;
        w_pend_d = r_pend_q;

        if (i_wr) begin
            w_shd_d = i_wdata;
        end

        if (i_resync) begin
            w_cnt_d  = '0;
            w_sq_d   = 1'b0;
            w_pend_d = 1'b0;
            w_act_d  = i_wr ? i_wdata : r_shd_q;
        end else if (!i_en) begin
            if (i_wr) begin
                w_act_d  = i_wdata;
                w_pend_d = 1'b0;
            end
        end else if (w_wrap) begin
            w_cnt_d  = '0;
            w_tick_d = 1'b1;
            w_sq_d   = 1'b1;
            w_act_d  = i_wr ? i_wdata : r_shd_q;
            w_pend_d = 1'b0;
        end else begin
            w_cnt_d = w_cnt_inc;
            if (w_cnt_inc == w_half) begin
                w_sq_d = 1'b0;
            end
            if (i_wr) begin
                w_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q  <= '0;
            r_act_q  <= c_def;
            r_shd_q  <= c_def;
            r_tick_q <= 1'b0;
            r_sq_q   <= 1'b0;
            r_pend_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_act_q  <= w_act_d;
            r_shd_q  <= w_shd_d;
            r_tick_q <= w_tick_d;
            r_sq_q   <= w_sq_d;
            r_pend_q <= w_pend_d;
        end
    end

    assign o_out.tick = r_tick_q;
    assign o_out.sq   = r_sq_q;
    assign o_out.pend = r_pend_q;

endmodule : freq_div_channel
`default_nettype wire

// File: rtl/freq_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : freq_div_multi
//  Description : N_CH programmable clock-enable/square-wave dividers; decodes
//                divisor writes, clamps the value and fans out resync.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_div_multi
    import freq_div_multi_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DIV_W   = 26,
    parameter int DEF_DIV = DIV_1HZ,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             resync,
    input  logic             div_wr,
    input  logic [CH_W-1:0]  div_sel,
    input  logic [DIV_W-1:0] div_data,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq,
    output logic [N_CH-1:0]  pend
);

    localparam logic [DIV_W-1:0] c_div_min = DIV_W'(DIV_MIN);

    logic [DIV_W-1:0] w_div_clamped;
    logic [N_CH-1:0]  w_wr;

    assign w_div_clamped = (div_data < c_div_min) ? c_div_min : div_data;

    // Select values at or above N_CH match no channel and are dropped.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        ch_out_t w_out;

        assign w_wr[gi] = div_wr & (div_sel == CH_W'(gi));

        freq_div_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_en     (ch_en[gi]),
            .i_resync (resync),
            .i_wr     (w_wr[gi]),
            .i_wdata  (w_div_clamped),
            .o_out    (w_out)
        );

        assign tick[gi] = w_out.tick;
        assign sq[gi]   = w_out.sq;
        assign pend[gi] = w_out.pend;
    end

endmodule : freq_div_multi
`default_nettype wire
